// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and defaults for the SPI target
package spi_pkg;

  localparam int SPI_WIDTH = 8;

  typedef enum logic [1:0] {
    S_WAIT_DESELECT,
    S_IDLE,
    S_ACTIVE
  } spi_target_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - two-flop synchroniser with rise/fall strobes for one async pin
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync_q;
  logic hist_q;

  // Resync the pin and keep one cycle of history; all flops clear to 0 so a
  // pin already low at reset release produces no edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta   <= 1'b0;
      sync_q <= 1'b0;
      hist_q <= 1'b0;
    end else begin
      meta   <= pin;
      sync_q <= meta;
      hist_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~hist_q;
  assign fall  = ~sync_q & hist_q;

endmodule

// File: rtl/spi_target.sv
// rtl/spi_target.sv - SPI mode 0 target: oversampled pins, rx deserialiser, buffered tx serialiser
module spi_target
  import spi_pkg::*;
#(
  parameter int              WIDTH      = SPI_WIDTH,
  parameter logic [WIDTH-1:0] TX_DEFAULT = WIDTH'('hFF)
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             select,
  input  logic             sck,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic             tx_underrun,
  output logic             frame_abort,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  spi_target_state_t state, state_next;

  logic cs_level, cs_rise, cs_fall;
  logic sck_level, sck_rise, sck_fall;
  logic mosi_sync, mosi_rise, mosi_fall;
  logic unused_ok;

  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] rx_shift;
  logic [WIDTH-1:0] rx_next;
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] tx_buf;
  logic             tx_full;
  logic             word_done;

  logic word_start;
  logic rx_step;
  logic tx_step;
  logic frame_end;

  sync_edge_detect u_cs   (.clk(clk_in), .reset(reset_in), .pin(select),
                           .level(cs_level), .rise(cs_rise), .fall(cs_fall));
  sync_edge_detect u_sck  (.clk(clk_in), .reset(reset_in), .pin(sck),
                           .level(sck_level), .rise(sck_rise), .fall(sck_fall));
  sync_edge_detect u_mosi (.clk(clk_in), .reset(reset_in), .pin(mosi),
                           .level(mosi_sync), .rise(mosi_rise), .fall(mosi_fall));

  assign unused_ok = &{1'b0, sck_level, mosi_rise, mosi_fall};

  // State register.
  always_ff @(posedge clk_in) begin
    if (reset_in) state <= S_WAIT_DESELECT;
    else          state <= state_next;
  end

  // Next state plus the per-cycle action strobes; cs edges outrank sck edges.
  always_comb begin
    state_next = state;
    word_start = 1'b0;
    rx_step    = 1'b0;
    tx_step    = 1'b0;
    frame_end  = 1'b0;
    case (state)
      S_WAIT_DESELECT: if (cs_level) state_next = S_IDLE;
      S_IDLE: begin
        if (cs_fall) begin
          state_next = S_ACTIVE;
          word_start = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (cs_rise) begin
          state_next = S_IDLE;
          frame_end  = 1'b1;
        end else begin
          rx_step = sck_rise;
          if (sck_fall) begin
            word_start = word_done;
            tx_step    = ~word_done;
          end
        end
      end
      default: state_next = S_WAIT_DESELECT;
    endcase
  end

  assign rx_next = {rx_shift[WIDTH-2:0], mosi_sync};

  // Datapath: tx buffer handshake, tx shifter/miso, rx shifter, bit counting.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      miso        <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      tx_buf      <= '0;
      tx_full     <= 1'b0;
      word_done   <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;

      // A load racing an empty-buffer word start is kept for the next word.
      if (tx_load && !tx_full) begin
        tx_buf  <= tx_data;
        tx_full <= 1'b1;
      end

      if (word_start) begin
        word_done <= 1'b0;
        if (tx_full) begin
          tx_shift <= tx_buf;
          miso     <= tx_buf[WIDTH-1];
          tx_full  <= 1'b0;
        end else begin
          tx_shift    <= TX_DEFAULT;
          miso        <= TX_DEFAULT[WIDTH-1];
          tx_underrun <= 1'b1;
        end
      end

      if (tx_step) begin
        tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
        miso     <= tx_shift[WIDTH-2];
      end

      if (rx_step) begin
        rx_shift <= rx_next;
        if (bit_cnt == CW'(WIDTH - 1)) begin
          rx_data   <= rx_next;
          rx_valid  <= 1'b1;
          bit_cnt   <= '0;
          word_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + CW'(1);
        end
      end

      if (frame_end) begin
        if (bit_cnt != '0) frame_abort <= 1'b1;
        bit_cnt   <= '0;
        word_done <= 1'b0;
      end
    end
  end

  assign tx_ready = ~tx_full;
  assign busy     = (state == S_ACTIVE);
  assign miso_oe  = busy;

endmodule

// File: tb/tb_spi_target.sv
// tb/tb_spi_target.sv - randomized self-checking bench for spi_target with a buffer/word-level model
module tb_spi_target;

  logic       clk_in = 1'b0;
  logic       reset_in, select, sck, mosi, tx_load;
  logic [7:0] tx_data;
  logic       miso, miso_oe, rx_valid, tx_ready, tx_underrun, frame_abort, busy;
  logic [7:0] rx_data;

  int checks = 0;
  int errors = 0;

  // Reference model: one-deep response buffer, counts of expected pulses.
  bit         m_full = 1'b0;
  logic [7:0] m_buf  = 8'h00;
  int         m_under = 0;
  int         m_abort = 0;

  // Observations gathered from the DUT outputs.
  int         under_seen = 0;
  int         abort_seen = 0;
  logic [7:0] rx_q[$];

  spi_target dut (
    .clk_in(clk_in), .reset_in(reset_in), .select(select), .sck(sck), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .tx_underrun(tx_underrun), .frame_abort(frame_abort), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (rx_valid)    rx_q.push_back(rx_data);
    if (tx_underrun) under_seen++;
    if (frame_abort) abort_seen++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // Word start as seen by the controller: buffered word if any, else default.
  function automatic logic [7:0] m_start();
    if (m_full) begin
      m_full = 1'b0;
      return m_buf;
    end
    m_under++;
    return 8'hFF;
  endfunction

  task automatic load_word(input logic [7:0] v);
    checks++;
    if (tx_ready !== ~m_full)
      $display("FAIL tx_ready_before_load: got %b expected %b", tx_ready, ~m_full);
    tx_data = v;
    tx_load = 1'b1;
    if (!m_full) begin
      m_full = 1'b1;
      m_buf  = v;
    end
    wait_cycles(1);
    tx_load = 1'b0;
  endtask

  // Mode 0 bit clocking; miso is sampled just before each rising edge.
  task automatic xfer_bits(input logic [7:0] w, input int nbits, input int half,
                           input bit do_load, input logic [7:0] lv, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = w[7-i];
      wait_cycles(half);
      got = {got[6:0], miso};
      sck = 1'b1;
      if (do_load && i == 2) begin
        load_word(lv);
        wait_cycles(half - 1);
      end else begin
        wait_cycles(half);
      end
      sck = 1'b0;
    end
  endtask

  task automatic do_frame(input int nw, input int half, input logic [7:0] w[4],
                          input bit ld[4], input logic [7:0] lv[4]);
    logic [7:0] cur, got;
    logic [7:0] exp_rx[$];
    rx_q.delete();
    select = 1'b0;
    cur = m_start();
    wait_cycles(4);
    checks++;
    if (under_seen !== m_under) begin
      errors++;
      $display("FAIL underrun_at_start: got %0d expected %0d", under_seen, m_under);
    end
    checks++;
    if ({busy, miso_oe, tx_ready} !== {1'b1, 1'b1, ~m_full}) begin
      errors++;
      $display("FAIL frame_start_flags: got %b expected %b", {busy, miso_oe, tx_ready}, {1'b1, 1'b1, ~m_full});
    end
    for (int k = 0; k < nw; k++) begin
      xfer_bits(w[k], 8, half, ld[k], lv[k], got);
      checks++;
      if (got !== cur) begin
        errors++;
        $display("FAIL miso_word%0d: got %h expected %h", k, got, cur);
      end
      cur = m_start();
      exp_rx.push_back(w[k]);
    end
    wait_cycles(half);
    select = 1'b1;
    wait_cycles(6);
    checks++;
    if (rx_q.size() !== exp_rx.size()) begin
      errors++;
      $display("FAIL rx_count: got %0d expected %0d", rx_q.size(), exp_rx.size());
    end else begin
      for (int k = 0; k < exp_rx.size(); k++) begin
        checks++;
        if (rx_q[k] !== exp_rx[k]) begin
          errors++;
          $display("FAIL rx_word%0d: got %h expected %h", k, rx_q[k], exp_rx[k]);
        end
      end
    end
    checks++;
    if (rx_data !== w[nw-1]) begin
      errors++;
      $display("FAIL rx_data_held: got %h expected %h", rx_data, w[nw-1]);
    end
    checks++;
    if ({under_seen, abort_seen} !== {m_under, m_abort}) begin
      errors++;
      $display("FAIL pulse_counts: got under=%0d abort=%0d expected under=%0d abort=%0d",
               under_seen, abort_seen, m_under, m_abort);
    end
    checks++;
    if ({busy, miso_oe} !== 2'b00) begin
      errors++;
      $display("FAIL frame_end_idle: got %b expected 00", {busy, miso_oe});
    end
  endtask

  task automatic test_reset();
    reset_in = 1'b1; select = 1'b1; sck = 1'b0; mosi = 1'b0;
    tx_load = 1'b0; tx_data = 8'h00;
    wait_cycles(3);
    checks++;
    if ({miso, miso_oe, rx_data, rx_valid, tx_ready, tx_underrun, frame_abort, busy} !== 15'b0_0_00000000_0_1_0_0_0) begin
      errors++;
      $display("FAIL reset_values: got %b expected %b",
               {miso, miso_oe, rx_data, rx_valid, tx_ready, tx_underrun, frame_abort, busy}, 15'b0_0_00000000_0_1_0_0_0);
    end
    reset_in = 1'b0;
    m_full = 1'b0;
    wait_cycles(6);
  endtask

  task automatic test_basic();
    logic [7:0] w[4] = '{8'h3C, 8'h00, 8'h00, 8'h00};
    bit         ld[4] = '{default: 1'b0};
    logic [7:0] lv[4] = '{default: 8'h00};
    load_word(8'hA5);
    do_frame(1, 5, w, ld, lv);
  endtask

  task automatic test_underrun();
    logic [7:0] w[4] = '{default: 8'h00};
    bit         ld[4] = '{default: 1'b0};
    logic [7:0] lv[4] = '{default: 8'h00};
    do_frame(1, 5, w, ld, lv);
  endtask

  task automatic test_two_words();
    logic [7:0] w[4];
    bit         ld[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] lv[4] = '{8'h34, 8'h00, 8'h00, 8'h00};
    for (int k = 0; k < 4; k++) w[k] = 8'($urandom);
    load_word(8'h12);
    do_frame(2, 5, w, ld, lv);
  endtask

  task automatic test_abort();
    logic [7:0] cur, got, w5;
    logic [7:0] w[4];
    bit         ld[4] = '{default: 1'b0};
    logic [7:0] lv[4] = '{default: 8'h00};
    for (int k = 0; k < 4; k++) w[k] = 8'($urandom);
    w5 = 8'($urandom);
    load_word(8'($urandom));
    rx_q.delete();
    select = 1'b0;
    cur = m_start();
    wait_cycles(4);
    xfer_bits(w5, 5, 5, 1'b0, 8'h00, got);
    checks++;
    if (got[4:0] !== cur[7:3]) begin
      errors++;
      $display("FAIL abort_partial_miso: got %b expected %b", got[4:0], cur[7:3]);
    end
    wait_cycles(5);
    select = 1'b1;
    m_abort++;
    wait_cycles(6);
    checks++;
    if ({abort_seen, rx_q.size()} !== {m_abort, 0}) begin
      errors++;
      $display("FAIL abort_pulse: got abort=%0d rx=%0d expected abort=%0d rx=0", abort_seen, rx_q.size(), m_abort);
    end
    do_frame(1, 5, w, ld, lv);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] got;
    logic [7:0] w[4];
    bit         ld[4] = '{default: 1'b0};
    logic [7:0] lv[4] = '{default: 8'h00};
    for (int k = 0; k < 4; k++) w[k] = 8'($urandom);
    load_word(8'($urandom));
    rx_q.delete();
    select = 1'b0;
    void'(m_start());
    wait_cycles(4);
    xfer_bits(8'($urandom), 3, 5, 1'b0, 8'h00, got);
    reset_in = 1'b1;
    wait_cycles(1);
    checks++;
    if ({miso, miso_oe, rx_data, rx_valid, tx_ready, tx_underrun, frame_abort, busy} !== 15'b0_0_00000000_0_1_0_0_0) begin
      errors++;
      $display("FAIL reset_mid_frame: got %b expected %b",
               {miso, miso_oe, rx_data, rx_valid, tx_ready, tx_underrun, frame_abort, busy}, 15'b0_0_00000000_0_1_0_0_0);
    end
    wait_cycles(1);
    reset_in = 1'b0;
    m_full = 1'b0;
    xfer_bits(8'($urandom), 8, 5, 1'b0, 8'h00, got);
    wait_cycles(5);
    checks++;
    if ({rx_q.size(), busy, under_seen, abort_seen} !== {0, 1'b0, m_under, m_abort}) begin
      errors++;
      $display("FAIL ignored_after_reset: got rx=%0d busy=%b under=%0d abort=%0d expected rx=0 busy=0 under=%0d abort=%0d",
               rx_q.size(), busy, under_seen, abort_seen, m_under, m_abort);
    end
    select = 1'b1;
    wait_cycles(6);
    do_frame(1, 5, w, ld, lv);
  endtask

  task automatic test_load_while_full();
    logic [7:0] w[4];
    bit         ld[4];
    logic [7:0] lv[4];
    for (int k = 0; k < 4; k++) w[k] = 8'($urandom);
    ld = '{default: 1'b0};
    lv = '{default: 8'h00};
    load_word(8'($urandom_range(0, 8'hED)));
    load_word(8'hEE);
    do_frame(1, 4, w, ld, lv);
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 4; k++) begin
        w[k]  = 8'($urandom);
        ld[k] = 1'($urandom);
        lv[k] = 8'($urandom);
      end
      if ($urandom_range(0, 1) == 1) load_word(8'($urandom));
      do_frame(int'($urandom_range(1, 3)), 4, w, ld, lv);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w[4];
    bit         ld[4];
    logic [7:0] lv[4];
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < 4; k++) begin
        w[k]  = 8'($urandom);
        ld[k] = 1'($urandom);
        lv[k] = 8'($urandom);
      end
      if ($urandom_range(0, 1) == 1) load_word(8'($urandom));
      do_frame(int'($urandom_range(1, 3)), int'($urandom_range(4, 7)), w, ld, lv);
    end
  endtask

  initial begin
    reset_in = 1'b1; select = 1'b1; sck = 1'b0; mosi = 1'b0;
    tx_load = 1'b0; tx_data = 8'h00;
    test_reset();
    test_basic();
    test_underrun();
    test_two_words();
    test_abort();
    test_reset_mid_frame();
    test_load_while_full();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
